// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - bit-serial MSB-first magnitude comparator with start/done handshake
// Optional macro: SIGNED_COMPARE_EN (two's-complement operands; only the sign bit resolves inversely)
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             l
);

  localparam int IDXW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_reg, a_reg_n;
  logic [WIDTH-1:0] b_reg, b_reg_n;
  logic [IDXW-1:0]  index, index_n;
  logic             g_n, e_n, l_n, done_n;

  logic             abit, bbit;
  logic             sign_pos;
  logic             a_wins, b_wins;

  assign abit = a_reg[index];
  assign bbit = b_reg[index];

`ifdef SIGNED_COMPARE_EN
  // A set sign bit means the smaller value, so the MSB decision is swapped.
  assign sign_pos = (index == LAST);
`else
  assign sign_pos = 1'b0;
`endif

  assign a_wins = sign_pos ? (~abit & bbit) : (abit & ~bbit);
  assign b_wins = sign_pos ? (abit & ~bbit) : (~abit & bbit);

  assign busy = (state == COMPARE);

  // State, operand, index and result registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      index <= LAST;
      g     <= 1'b0;
      e     <= 1'b0;
      l     <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      a_reg <= a_reg_n;
      b_reg <= b_reg_n;
      index <= index_n;
      g     <= g_n;
      e     <= e_n;
      l     <= l_n;
      done  <= done_n;
    end
  end

  // Next-state logic: accept in IDLE, then walk down the bits until one differs.
  always_comb begin
    state_n = state;
    a_reg_n = a_reg;
    b_reg_n = b_reg;
    index_n = index;
    g_n     = g;
    e_n     = e;
    l_n     = l;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          a_reg_n = a;
          b_reg_n = b;
          index_n = LAST;
          state_n = COMPARE;
        end
      end
      COMPARE: begin
        if (a_wins) begin
          g_n = 1'b1; e_n = 1'b0; l_n = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (b_wins) begin
          g_n = 1'b0; e_n = 1'b0; l_n = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (index == '0) begin
          g_n = 1'b0; e_n = 1'b1; l_n = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          index_n = index - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Parametrised, sequential successor to the 1-bit comparator.
- Compares two WIDTH-bit operands bit-serially, MSB first, reusing one-bit greater/equal/less logic each cycle.
- Uses a start/done handshake and terminates early at the first differing bit.
- Used where area matters more than latency, e.g. sorting and threshold checks in later labs.

Parameters:
- WIDTH, 8, operand width in bits; legal range WIDTH >= 2; index counter width is $clog2(WIDTH).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low; sampled on clk rising edge
- start  input  1  request a comparison; honoured only in IDLE
- a  input  WIDTH  operand A; sampled only on the accepting edge
- b  input  WIDTH  operand B; sampled only on the accepting edge
- busy  output  1  high while in COMPARE
- done  output  1  one-cycle pulse: g/e/l valid and newly updated
- g  output  1  A > B (registered, held)
- e  output  1  A == B (registered, held)
- l  output  1  A < B (registered, held)

Behaviour:
- Reset: rst_n low at a rising edge forces the following, regardless of state (including mid-compare): state=IDLE, busy=0, done=0, g=0, e=0, l=0, operand registers cleared, index=WIDTH-1.
- States: IDLE, COMPARE.
- IDLE:
  - done is 0 unless a result was produced on the previous edge.
  - start=1 at an edge latches a and b into internal registers, sets index=WIDTH-1, moves to COMPARE, and sets busy=1.
  - g/e/l keep their previous values until the new result.
- COMPARE, each edge examines bit [index] of the latched operands:
  - abit=1, bbit=0: g=1, e=0, l=0, done=1, go to IDLE (early exit).
  - abit=0, bbit=1: g=0, e=0, l=1, done=1, go to IDLE.
  - Bits equal and index==0: g=0, e=1, l=0, done=1, go to IDLE.
  - Bits equal and index>0: index decrements, stay in COMPARE, done=0.
- Latency from the accepting edge to done: k edges, where k = WIDTH - p and p is the position of the highest differing bit.
  - Equal operands: k = WIDTH.
  - Minimum k = 1 (MSB differs).
  - Maximum k = WIDTH.
- done is high for exactly one cycle. busy falls on the same edge that raises done.
- Exactly one of g/e/l is high after the first completed comparison. All three are 0 only after reset.
- start while busy=1 is ignored: no restart, operands not re-latched.
- Back-to-back: start=1 in the cycle where done=1 (state IDLE) is accepted. The new comparison begins with no idle gap, and the old result stays on g/e/l until the new done.
- Changes on a/b after the accepting edge have no effect on the current comparison.
- Reset asserted in the same cycle as start: reset wins.

Optional Feature:
- Macro: SIGNED_COMPARE_EN.
- Defined: operands are two's complement. Only at index==WIDTH-1, differing bits resolve inversely:
  - abit=1, bbit=0 gives l=1.
  - abit=0, bbit=1 gives g=1.
  - All lower bits compare as unsigned. Latency is unchanged.
- Not defined: pure unsigned comparison. No extra logic or ports in either case.

Test Plan:
- WIDTH=8, a=8'hA5, b=8'hA5, start 1 cycle -> busy=1 for 8 cycles; done pulses on 8th edge after accept; e=1, g=0, l=0.
- a=8'h80, b=8'h7F -> done on 1st edge after accept.
  - Unsigned: g=1.
  - With SIGNED_COMPARE_EN: l=1.
- a=8'h12, b=8'h13 (differ only at bit 0) -> done on 8th edge; l=1. Then, in the done cycle, start with a=8'h40, b=8'h20 -> accepted immediately; done 2 edges later with g=1.
- During a compare of a=8'h00, b=8'h01, pulse start with a=8'hFF, b=8'h00 at cycle 3 -> ignored; final result l=1 on 8th edge.
- Reset mid-operation: accept a=8'h01, b=8'h01, drive rst_n=0 at cycle 4 -> next edge busy=0, done=0, g=e=l=0. Release rst_n, issue a new start -> normal full-latency result.
- Idle hold: after a result with g=1, hold start=0 for 20 cycles -> g stays 1, done stays 0, busy stays 0.
